// File: rtl/apb4_pkg.sv
// ============================================================================
// Module   : apb4_pkg
// Purpose  : Shared APB4 types and constants for the command-driven master.
// Revision : 1.0
// ============================================================================
`default_nettype none

package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam logic [2:0] c_pprot_idle = 3'b000;

  localparam int unsigned c_apb_aw = 32;
  localparam int unsigned c_apb_dw = 32;

  typedef struct packed {
    logic                    write;
    logic [c_apb_aw-1:0]     addr;
    logic [c_apb_dw-1:0]     wdata;
    logic [c_apb_dw/8-1:0]   strb;
    logic [2:0]              prot;
  } apb_cmd_t;

  typedef struct packed {
    logic [c_apb_dw-1:0]     rdata;
    logic                    err;
    logic                    tout;
  } apb_rsp_t;

endpackage

`default_nettype wire

// File: rtl/apb4_wdog_cnt.sv
// ============================================================================
// Module   : apb4_wdog_cnt
// Purpose  : Saturating wait-state counter; hit flags the cycle whose wait
//            brings the count to MAX (never fires when MAX is 0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb4_wdog_cnt #(
  parameter int unsigned MAX = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic hit_o
);

  localparam int unsigned   c_w   = (MAX == 0) ? 1 : $clog2(MAX + 1);
  localparam logic [c_w-1:0] c_max = c_w'(MAX);

  logic [c_w-1:0] cnt_q;
  logic [c_w-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != c_max)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  generate
    if (MAX == 0) begin : g_off
      assign hit_o = 1'b0;
    end else begin : g_on
      localparam logic [c_w-1:0] c_last = c_w'(MAX - 1);
      assign hit_o = en_i && (cnt_q >= c_last);
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/apb4_cmd_master.sv
// ============================================================================
// Module   : apb4_cmd_master
// Purpose  : Valid/ready command stream to single APB4 transfers, with a
//            PREADY watchdog and a valid/ready response stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module apb4_cmd_master
  import apb4_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    rsp_tout_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int unsigned c_strb_w = DATA_WIDTH / 8;

  apb_state_e              state_q,     state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    psel_q,      psel_d;
  logic                    penable_q,   penable_d;
  logic                    pwrite_q,    pwrite_d;
  logic [ADDR_WIDTH-1:0]   paddr_q,     paddr_d;
  logic [2:0]              pprot_q,     pprot_d;
  logic [DATA_WIDTH-1:0]   pwdata_q,    pwdata_d;
  logic [c_strb_w-1:0]     pstrb_q,     pstrb_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q,   rsp_err_d;
  logic                    rsp_tout_q,  rsp_tout_d;

  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_hit;

  // Counter is cleared while in SETUP so it reads zero on the first ACCESS cycle.
  assign w_wd_clr = (state_q == ST_SETUP);
  assign w_wd_en  = (state_q == ST_ACCESS) && !pready_i;

  apb4_wdog_cnt #(
    .MAX (TIMEOUT)
  ) u_wdog (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr_i   (w_wd_clr),
    .en_i    (w_wd_en),
    .hit_o   (w_wd_hit)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pprot_d     = pprot_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rsp_tout_d  = rsp_tout_q;

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d     = ST_SETUP;
          req_ready_d = 1'b0;
          psel_d      = 1'b1;
          pwrite_d    = req_write_i;
          paddr_d     = req_addr_i;
          pprot_d     = req_prot_i;
          pwdata_d    = req_write_i ? req_wdata_i : '0;
          pstrb_d     = req_write_i ? req_strb_i  : '0;
        end
      end
      ST_SETUP: begin
        state_d   = ST_ACCESS;
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        // w_wd_hit is gated by !pready_i, so a late PREADY still completes normally.
        if (pready_i || w_wd_hit) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pready_i ? pslverr_i : 1'b1;
          rsp_tout_d  = !pready_i;
          rsp_rdata_d = (pready_i && !pwrite_q) ? prdata_i : '0;
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          pwrite_d    = 1'b0;
          paddr_d     = '0;
          pprot_d     = c_pprot_idle;
          pwdata_d    = '0;
          pstrb_d     = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b0;
          rsp_tout_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b1;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pprot_q     <= c_pprot_idle;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_tout_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pprot_q     <= pprot_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rsp_tout_q  <= rsp_tout_d;
    end
  end

  assign req_ready_o = req_ready_q;
  assign psel_o      = psel_q;
  assign penable_o   = penable_q;
  assign pwrite_o    = pwrite_q;
  assign paddr_o     = paddr_q;
  assign pprot_o     = pprot_q;
  assign pwdata_o    = pwdata_q;
  assign pstrb_o     = pstrb_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_tout_o  = rsp_tout_q;

endmodule

`default_nettype wire

// File: tb/tb_apb4_cmd_master.sv
// ============================================================================
// Module   : tb_apb4_cmd_master
// Purpose  : Directed bench with an APB slave model and a response scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_apb4_cmd_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [3:0]  req_strb_i = '0;
  logic [2:0]  req_prot_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b1;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        rsp_tout_o;
  logic [31:0] paddr_o;
  logic [2:0]  pprot_o;
  logic        psel_o;
  logic        penable_o;
  logic        pwrite_o;
  logic [31:0] pwdata_o;
  logic [3:0]  pstrb_o;
  logic [31:0] prdata_i = '0;
  logic        pready_i = 1'b0;
  logic        pslverr_i = 1'b0;

  always #5 clk = ~clk;

  apb4_cmd_master #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .TIMEOUT    (8)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .req_strb_i  (req_strb_i),
    .req_prot_i  (req_prot_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .rsp_tout_o  (rsp_tout_o),
    .paddr_o     (paddr_o),
    .pprot_o     (pprot_o),
    .psel_o      (psel_o),
    .penable_o   (penable_o),
    .pwrite_o    (pwrite_o),
    .pwdata_o    (pwdata_o),
    .pstrb_o     (pstrb_o),
    .prdata_i    (prdata_i),
    .pready_i    (pready_i),
    .pslverr_i   (pslverr_i)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        tout;
  } rsp_t;

  rsp_t exp_q[$];
  rsp_t mon_e;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   hs_cyc = -1;
  int   acc_cyc = -1;

  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  bit          slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc_k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Slave: PREADY on the (slv_wait+1)-th ACCESS cycle; junk data/err while not ready.
  always @(posedge clk) begin
    #1;
    if (psel_o && penable_o) begin
      if (!slv_never && acc_k == slv_wait) begin
        pready_i  = 1'b1;
        prdata_i  = slv_rdata;
        pslverr_i = slv_err;
      end else begin
        pready_i  = 1'b0;
        prdata_i  = 32'hFFFF_0000;
        pslverr_i = 1'b1;
      end
      acc_k++;
    end else begin
      pready_i  = 1'b0;
      prdata_i  = 32'hFFFF_0000;
      pslverr_i = 1'b1;
      acc_k     = 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid_o && rsp_ready_i) begin
      hs_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected: got rdata=%h err=%b, expected no response", rsp_rdata_o, rsp_err_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata_o, mon_e.rdata);
        chk("rsp_err", {31'd0, rsp_err_o}, {31'd0, mon_e.err});
        chk("rsp_tout", {31'd0, rsp_tout_o}, {31'd0, mon_e.tout});
      end
    end
  end

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] strb, input logic [2:0] prot,
                       input logic [31:0] e_rdata, input logic e_err, input logic e_tout);
    int   n;
    logic acc;
    n = 0;
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = addr;
    req_wdata_i = wdata;
    req_strb_i  = strb;
    req_prot_i  = prot;
    do begin
      acc     = req_ready_o;
      acc_cyc = cyc;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    req_valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_accept: got no accept in %0d cycles, expected accept", n);
    end else begin
      exp_q.push_back('{e_rdata, e_err, e_tout});
    end
  endtask

  task automatic wait_rsp(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rsp_valid_o && rsp_ready_i) && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      checks++;
      errors++;
      $display("FAIL %s: got no response handshake, expected one", name);
    end
    @(posedge clk);
    #1;
  endtask

  // Called from the SETUP cycle; counts ACCESS cycles and checks request stability.
  task automatic count_access(input logic [31:0] addr, input logic [3:0] strb,
                              output int n, output bit stable);
    n = 0;
    stable = 1'b1;
    @(posedge clk);
    #1;
    while (psel_o && penable_o && n < 50) begin
      if (paddr_o !== addr || pstrb_o !== strb) stable = 1'b0;
      n++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200us");
    $fatal(1);
  end

  initial begin
    int          n;
    bit          ok;
    bit          psel_seen;
    logic [31:0] snap_rdata;
    logic        snap_err;
    logic        snap_tout;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_psel", {31'd0, psel_o}, 32'd0);
    chk("rst_penable", {31'd0, penable_o}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst_paddr", paddr_o, 32'd0);

    // 1: write, immediate PREADY
    slv_wait = 0; slv_err = 1'b0; slv_never = 1'b0;
    issue(1'b1, 32'h0200_4000, 32'hDEAD_BEEF, 4'hF, 3'b000, 32'd0, 1'b0, 1'b0);
    chk("t1_setup_psel", {31'd0, psel_o}, 32'd1);
    chk("t1_setup_penable", {31'd0, penable_o}, 32'd0);
    chk("t1_setup_paddr", paddr_o, 32'h0200_4000);
    chk("t1_setup_pwdata", pwdata_o, 32'hDEAD_BEEF);
    chk("t1_setup_pstrb", {28'd0, pstrb_o}, 32'hF);
    chk("t1_setup_pwrite", {31'd0, pwrite_o}, 32'd1);
    chk("t1_setup_req_ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    chk("t1_access_psel", {31'd0, psel_o}, 32'd1);
    chk("t1_access_penable", {31'd0, penable_o}, 32'd1);
    @(posedge clk);
    #1;
    chk("t1_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    chk("t1_resp_psel", {31'd0, psel_o}, 32'd0);
    chk("t1_resp_penable", {31'd0, penable_o}, 32'd0);
    chk("t1_resp_paddr", paddr_o, 32'd0);
    chk("t1_resp_pwdata", pwdata_o, 32'd0);
    wait_rsp("t1_rsp");
    chk("t1_idle_req_ready", {31'd0, req_ready_o}, 32'd1);

    // 2: read with 3 wait states
    slv_wait = 3; slv_rdata = 32'h1234_5678; slv_err = 1'b0;
    issue(1'b0, 32'h0200_BFF8, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h1234_5678, 1'b0, 1'b0);
    chk("t2_read_pstrb", {28'd0, pstrb_o}, 32'd0);
    chk("t2_read_pwdata", pwdata_o, 32'd0);
    chk("t2_read_pwrite", {31'd0, pwrite_o}, 32'd0);
    count_access(32'h0200_BFF8, 4'h0, n, ok);
    chk("t2_access_cycles", n, 32'd4);
    chk("t2_addr_stable", {31'd0, ok}, 32'd1);
    wait_rsp("t2_rsp");

    // 3: read with PSLVERR, then back-to-back command
    slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'hCAFE_F00D;
    issue(1'b0, 32'h0200_0008, 32'd0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b1, 1'b0);
    issue(1'b0, 32'h0200_000C, 32'd0, 4'h0, 3'b000, 32'hCAFE_F00D, 1'b1, 1'b0);
    chk("t3_accept_after_hs", acc_cyc, hs_cyc + 1);
    wait_rsp("t3_rsp");

    // 4a: slave never ready -> timeout after 8 wait cycles
    slv_never = 1'b1; slv_err = 1'b0;
    issue(1'b0, 32'h0200_0100, 32'd0, 4'h0, 3'b000, 32'd0, 1'b1, 1'b1);
    count_access(32'h0200_0100, 4'h0, n, ok);
    chk("t4a_access_cycles", n, 32'd8);
    chk("t4a_psel_dropped", {31'd0, psel_o}, 32'd0);
    chk("t4a_rsp_valid", {31'd0, rsp_valid_o}, 32'd1);
    wait_rsp("t4a_rsp");

    // 4b: PREADY on the 8th ACCESS cycle -> normal completion
    slv_never = 1'b0; slv_wait = 7; slv_rdata = 32'h0BAD_F00D; slv_err = 1'b0;
    issue(1'b0, 32'h0200_0104, 32'd0, 4'h0, 3'b000, 32'h0BAD_F00D, 1'b0, 1'b0);
    count_access(32'h0200_0104, 4'h0, n, ok);
    chk("t4b_access_cycles", n, 32'd8);
    wait_rsp("t4b_rsp");

    // 5: response back-pressure with a pending command
    slv_wait = 0; slv_err = 1'b1; slv_rdata = 32'h7777_1111;
    rsp_ready_i = 1'b0;
    issue(1'b0, 32'h0200_4004, 32'd0, 4'h0, 3'b010, 32'h7777_1111, 1'b1, 1'b0);
    chk("t5_pprot", {29'd0, pprot_o}, 32'd2);
    req_valid_i = 1'b1;
    req_write_i = 1'b1;
    req_addr_i  = 32'h0200_4008;
    req_wdata_i = 32'h5A5A_5A5A;
    req_strb_i  = 4'h3;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    slv_err    = 1'b0;
    snap_rdata = rsp_rdata_o;
    snap_err   = rsp_err_o;
    snap_tout  = rsp_tout_o;
    ok         = 1'b1;
    psel_seen  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid_o || req_ready_o || rsp_rdata_o !== snap_rdata ||
          rsp_err_o !== snap_err || rsp_tout_o !== snap_tout) ok = 1'b0;
      if (psel_o) psel_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    chk("t5_hold_stable", {31'd0, ok}, 32'd1);
    chk("t5_no_psel", {31'd0, psel_seen}, 32'd0);
    chk("t5_snap_rdata", snap_rdata, 32'h7777_1111);
    rsp_ready_i = 1'b1;
    issue(1'b1, 32'h0200_4008, 32'h5A5A_5A5A, 4'h3, 3'b000, 32'd0, 1'b0, 1'b0);
    chk("t5_accept_after_hs", acc_cyc, hs_cyc + 1);
    wait_rsp("t5_rsp");

    // 6: reset during ACCESS
    slv_never = 1'b1;
    issue(1'b0, 32'h0200_0200, 32'd0, 4'h0, 3'b000, 32'd0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("t6_in_access", {31'd0, penable_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_psel", {31'd0, psel_o}, 32'd0);
    chk("t6_rst_penable", {31'd0, penable_o}, 32'd0);
    chk("t6_rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    void'(exp_q.pop_back());
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_req_ready", {31'd0, req_ready_o}, 32'd1);
    slv_never = 1'b0; slv_wait = 0; slv_err = 1'b0;
    issue(1'b1, 32'h0200_4000, 32'h0000_0001, 4'hF, 3'b000, 32'd0, 1'b0, 1'b0);
    wait_rsp("t6_rsp");

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
